psa_loader: RTL and testbench

- Byte-stream loader that fills the pattern BRAM and the block BRAM that the search engine reads.
- Parses framed commands from a host byte stream (valid/ready handshake) and issues BRAM write strobes.
- Latches the resulting pattern/block address and length (p, pl, b, bl) for the search engine, then pulses load_done so the host can assert activate.
- It is the writer side of the memory the search engine reads.

---
 rtl/psa_loader.sv | 174 +++++++++++++++++
 tb/tb_psa_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_loader.sv
`default_nettype none
//============================================================================
// Module   : psa_loader
// Purpose  : Parses framed commands (CMD, ADDR, LEN, LEN data bytes) from a
//            valid/ready byte stream, writes the bytes into the pattern or
//            block BRAM, then publishes start/length for the search engine
//            and pulses load_done.
// Revision : 1.0 - initial release
//============================================================================
module psa_loader #(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] CMD_PAT = 8'h50,
  parameter logic [DATA_W-1:0] CMD_BLK = 8'h42
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              search_busy,
  output logic              wea_p,
  output logic              wea_b,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic [ADDR_W-1:0] p,
  output logic [ADDR_W-1:0] pl,
  output logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] bl,
  output logic              load_done,
  output logic              err
);

  // Frame parser states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        r_state;
  logic              r_tgt_blk;   // 1 = block BRAM, 0 = pattern BRAM
  logic [ADDR_W-1:0] r_start;     // frame start address
  logic [ADDR_W-1:0] r_ptr;       // next write address
  logic [ADDR_W-1:0] r_len;       // frame length as received
  logic [ADDR_W-1:0] r_rem;       // data bytes still expected

  logic w_accept;
  logic w_cmd_ok;
  logic w_len_zero;

  assign w_accept   = in_valid & in_ready;
  assign w_cmd_ok   = (in_byte == CMD_PAT) || (in_byte == CMD_BLK);
  assign w_len_zero = (in_byte == '0);

  // Ready depends only on state and busy; held low while in reset
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE:                 in_ready = ~search_busy;
        S_ADDR, S_LEN, S_DATA:  in_ready = 1'b1;
        default:                in_ready = 1'b0;
      endcase
    end
  end

  // Frame parser: state, target select, pointer and remaining count
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tgt_blk <= 1'b0;
      r_start   <= '0;
      r_ptr     <= '0;
      r_len     <= '0;
      r_rem     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_cmd_ok) begin
            r_tgt_blk <= (in_byte == CMD_BLK);
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            r_start <= ADDR_W'(in_byte);
            r_ptr   <= ADDR_W'(in_byte);
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            if (w_len_zero) begin
              r_state <= S_IDLE;
            end else begin
              r_len   <= ADDR_W'(in_byte);
              r_rem   <= ADDR_W'(in_byte);
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            // Pointer wraps naturally at 2^ADDR_W
            r_ptr <= r_ptr + ADDR_W'(1);
            r_rem <= r_rem - ADDR_W'(1);
            if (r_rem == ADDR_W'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // BRAM write port: one-cycle strobe following each accepted data byte
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      wea_p <= 1'b0;
      wea_b <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      wea_p <= 1'b0;
      wea_b <= 1'b0;
      if ((r_state == S_DATA) && w_accept) begin
        wea_p <= ~r_tgt_blk;
        wea_b <= r_tgt_blk;
        addra <= r_ptr;
        dina  <= in_byte;
      end
    end
  end

  // Status pulses and published start/length for the search engine
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      load_done <= 1'b0;
      err       <= 1'b0;
      p         <= '0;
      pl        <= '0;
      b         <= '0;
      bl        <= '0;
    end else begin
      load_done <= 1'b0;
      err       <= 1'b0;
      if ((r_state == S_IDLE) && w_accept && !w_cmd_ok) begin
        err <= 1'b1;
      end
      if ((r_state == S_LEN) && w_accept && w_len_zero) begin
        err <= 1'b1;
      end
      if (r_state == S_DONE) begin
        load_done <= 1'b1;
        if (r_tgt_blk) begin
          b  <= r_start;
          bl <= r_len;
        end else begin
          p  <= r_start;
          pl <= r_len;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_psa_loader.sv
`default_nettype none
//============================================================================
// Module   : tb_psa_loader
// Purpose  : Self-checking bench for psa_loader. A frame-position model
//            predicts every output each cycle; directed frames exercise
//            pattern/block loads, gaps, wrap, errors, busy and reset.
// Revision : 1.0 - initial release
//============================================================================
module tb_psa_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       search_busy;
  logic       wea_p, wea_b;
  logic [7:0] addra, dina;
  logic [7:0] p, pl, b, bl;
  logic       load_done, err;

  int total  = 0;
  int passed = 0;

  psa_loader dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .search_busy(search_busy),
    .wea_p      (wea_p),
    .wea_b      (wea_b),
    .addra      (addra),
    .dina       (dina),
    .p          (p),
    .pl         (pl),
    .b          (b),
    .bl         (bl),
    .load_done  (load_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  // ---------------- Behavioural model ----------------
  // pos: 0 = expecting CMD, 1 = ADDR, 2 = LEN, 3 = data bytes
  int         pos = 0;
  bit         m_blk = 0;
  bit         m_done = 0;   // this cycle is the one after the final data byte
  logic [7:0] m_start = 0, m_len = 0, m_cnt = 0;
  logic       e_wea_p = 0, e_wea_b = 0, e_ld = 0, e_err = 0;
  logic [7:0] e_addra = 0, e_dina = 0;
  logic [7:0] e_p = 0, e_pl = 0, e_b = 0, e_bl = 0;
  int         np = 0, nb = 0, ne = 0, nld = 0;

  always @(negedge clk) begin
    logic cur_ready;
    logic acc;
    if (wea_p) np++;
    if (wea_b) nb++;
    if (err) ne++;
    if (load_done) nld++;
    if (!reset) begin
      pos = 0; m_done = 0;
      e_wea_p = 0; e_wea_b = 0; e_ld = 0; e_err = 0;
      e_addra = 0; e_dina = 0; e_p = 0; e_pl = 0; e_b = 0; e_bl = 0;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", {wea_p, wea_b, load_done, err, addra, dina}, 0);
      chk("rst_results", {p, pl, b, bl}, 0);
    end else begin
      cur_ready = m_done ? 1'b0 : ((pos == 0) ? !search_busy : 1'b1);
      chk("in_ready", in_ready, cur_ready);
      chk("wea_p", wea_p, e_wea_p);
      chk("wea_b", wea_b, e_wea_b);
      if (e_wea_p || e_wea_b) begin
        chk("addra", addra, e_addra);
        chk("dina", dina, e_dina);
      end
      chk("load_done", load_done, e_ld);
      chk("err", err, e_err);
      chk("p", p, e_p);
      chk("pl", pl, e_pl);
      chk("b", b, e_b);
      chk("bl", bl, e_bl);
      // Predict next cycle
      acc = in_valid && cur_ready;
      e_wea_p = 0; e_wea_b = 0; e_ld = 0; e_err = 0;
      if (m_done) begin
        e_ld = 1;
        if (m_blk) begin e_b = m_start; e_bl = m_len; end
        else       begin e_p = m_start; e_pl = m_len; end
        m_done = 0;
      end else if (acc) begin
        case (pos)
          0: if (in_byte == 8'h50 || in_byte == 8'h42) begin
               m_blk = (in_byte == 8'h42); pos = 1;
             end else e_err = 1;
          1: begin m_start = in_byte; pos = 2; end
          2: if (in_byte == 0) begin e_err = 1; pos = 0; end
             else begin m_len = in_byte; m_cnt = 0; pos = 3; end
          default: begin
            e_wea_p = !m_blk; e_wea_b = m_blk;
            e_addra = m_start + m_cnt;
            e_dina  = in_byte;
            m_cnt   = m_cnt + 8'd1;
            if (m_cnt == m_len) begin pos = 0; m_done = 1; end
          end
        endcase
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic send_byte(input logic [7:0] v);
    bit acc;
    int n;
    in_byte = v; in_valid = 1'b1; acc = 0; n = 0;
    while (!acc && n < 64) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("handshake_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s_np, s_nb, s_ne, s_nld;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_byte = 8'h00; search_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Pattern load
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(4);
    chk("pat_p", p, 8'h00); chk("pat_pl", pl, 8'h02);
    chk("pat_b", b, 8'h00); chk("pat_bl", bl, 8'h00);
    chk("pat_writes", np, 2); chk("pat_done_cnt", nld, 1);

    // Block load with a 3-cycle gap after the 5th data byte
    s_np = np; s_nb = nb;
    send_byte(8'h42); send_byte(8'h10); send_byte(8'h14);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i));
      if (i == 4) idle(3);
    end
    idle(4);
    chk("blk_b", b, 8'h10); chk("blk_bl", bl, 8'h14);
    chk("blk_writes", nb - s_nb, 20); chk("blk_no_wea_p", np - s_np, 0);

    // Address wrap FE, FF, 00
    s_nb = nb;
    send_byte(8'h42); send_byte(8'hFE); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(4);
    chk("wrap_b", b, 8'hFE); chk("wrap_bl", bl, 8'h03);
    chk("wrap_writes", nb - s_nb, 3);

    // Bad command, then zero-length frame
    s_ne = ne; s_np = np; s_nb = nb;
    send_byte(8'h77);
    idle(3);
    chk("badcmd_err", ne - s_ne, 1); chk("badcmd_ready", in_ready, 1);
    send_byte(8'h50); send_byte(8'h05); send_byte(8'h00);
    idle(3);
    chk("len0_err", ne - s_ne, 2);
    chk("len0_p", p, 8'h00); chk("len0_pl", pl, 8'h02);
    chk("err_no_writes", (np - s_np) + (nb - s_nb), 0);

    // Busy gating in IDLE
    search_busy = 1'b1; in_byte = 8'h50; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("busy_stall_ready", in_ready, 0);
    search_busy = 1'b0;
    send_byte(8'h50); send_byte(8'h80); send_byte(8'h02);
    send_byte(8'hC0); send_byte(8'hC1);
    idle(4);
    chk("busy_p", p, 8'h80); chk("busy_pl", pl, 8'h02);

    // Busy raised mid-frame
    s_nld = nld;
    send_byte(8'h42); send_byte(8'h90); send_byte(8'h02);
    search_busy = 1'b1;
    send_byte(8'hD0); send_byte(8'hD1);
    in_byte = 8'h50; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midbusy_done", nld - s_nld, 1);
    chk("midbusy_b", b, 8'h90); chk("midbusy_bl", bl, 8'h02);
    chk("midbusy_stall", in_ready, 0);
    search_busy = 1'b0;
    send_byte(8'h50); send_byte(8'h20); send_byte(8'h01); send_byte(8'hE0);
    idle(4);
    chk("after_busy_p", p, 8'h20); chk("after_busy_pl", pl, 8'h01);

    // Asynchronous reset after the first data byte
    s_nld = nld;
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h04); send_byte(8'h11);
    #2 reset = 1'b0;
    #1;
    chk("async_wea_p", wea_p, 0); chk("async_addra", addra, 0);
    chk("async_dina", dina, 0); chk("async_ready", in_ready, 0);
    chk("async_results", {p, pl, b, bl}, 0);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1);
    chk("rst_no_done", nld - s_nld, 0);
    send_byte(8'h50); send_byte(8'h30); send_byte(8'h02);
    send_byte(8'hC1); send_byte(8'hC2);
    idle(4);
    chk("fresh_p", p, 8'h30); chk("fresh_pl", pl, 8'h02);
    chk("fresh_b", b, 8'h00); chk("fresh_bl", bl, 8'h00);

    // Back-to-back frames with in_valid held high
    s_nld = nld;
    send_byte(8'h50); send_byte(8'h60); send_byte(8'h01); send_byte(8'h77);
    send_byte(8'h42); send_byte(8'h70); send_byte(8'h01); send_byte(8'h88);
    idle(4);
    chk("b2b_p", p, 8'h60); chk("b2b_pl", pl, 8'h01);
    chk("b2b_b", b, 8'h70); chk("b2b_bl", bl, 8'h01);
    chk("b2b_done", nld - s_nld, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
